// File: rtl/maxnet_engine_if.sv
// Request/result bundle between a Maxnet client and maxnet_engine.
// master: drives start/epsilon/a_in and observes busy/finish/results.
// slave : the engine side; it samples the request and drives the status and results.
interface maxnet_engine_if #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 16,
  parameter int unsigned MAX_ITER = 255
);
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ITW  = $clog2(MAX_ITER + 1);

  logic            start;
  logic [W-1:0]    epsilon;
  logic [N*W-1:0]  a_in;
  logic            busy;
  logic            finish;
  logic [W-1:0]    out;
  logic [IDXW-1:0] winner;
  logic [ITW-1:0]  iter_count;
  logic            tie;
  logic            timeout;

  modport master (
    output start, epsilon, a_in,
    input  busy, finish, out, winner, iter_count, tie, timeout
  );

  modport slave (
    input  start, epsilon, a_in,
    output busy, finish, out, winner, iter_count, tie, timeout
  );
endinterface

// File: rtl/maxnet_engine.sv
// Fixed-point Maxnet winner-take-all engine.
// Each iteration applies a_i <- max(0, a_i - eps*sum_{j!=i} a_j) until at most
// one activation is non-zero. The engine then reports the winner, the iteration count and the tie/timeout status.
// Ports: clk, rst (sync, active-high); bus (slave) carries start/epsilon/a_in
// and busy/finish/out/winner/iter_count/tie/timeout, all registered.
module maxnet_engine #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 16,
  parameter int unsigned F        = 8,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic            clk,
  input  logic            rst,
  maxnet_engine_if.slave  bus
);
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ITW  = $clog2(MAX_ITER + 1);
  localparam int unsigned SW   = W + IDXW;   // lossless sum width
  localparam int unsigned PW   = W + SW;     // full product width
  localparam int unsigned QW   = PW - F;     // product after fraction shift

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUM  = 2'd1;
  localparam logic [1:0] ST_UPD  = 2'd2;
  localparam logic [1:0] ST_CHK  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_q [N];
  logic [W-1:0]    a_d [N];
  logic [W-1:0]    shadow_q [N];
  logic [W-1:0]    shadow_d [N];
  logic [W-1:0]    eps_q, eps_d;
  logic [SW-1:0]   s_q, s_d;
  logic [IDXW-1:0] k_q, k_d;
  logic            busy_q, busy_d;
  logic            finish_q, finish_d;
  logic [W-1:0]    out_q, out_d;
  logic [IDXW-1:0] winner_q, winner_d;
  logic [ITW-1:0]  iter_q, iter_d;
  logic            tie_q, tie_d;
  logic            timeout_q, timeout_d;

  // Datapath helpers
  logic [SW-1:0]   sum_c;
  logic [W-1:0]    a_k_c;
  logic [SW-1:0]   diff_c;
  logic [PW-1:0]   prod_c;
  logic [QW-1:0]   p_c;
  logic [W-1:0]    upd_val_c;
  logic            any_nz_c;
  logic            multi_nz_c;
  logic [IDXW-1:0] first_idx_c;
  logic [ITW-1:0]  iter_inc_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      for (int i = 0; i < int'(N); i++) begin
        a_q[i]      <= '0;
        shadow_q[i] <= '0;
      end
      eps_q     <= '0;
      s_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      finish_q  <= 1'b0;
      out_q     <= '0;
      winner_q  <= '0;
      iter_q    <= '0;
      tie_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      shadow_q  <= shadow_d;
      eps_q     <= eps_d;
      s_q       <= s_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      finish_q  <= finish_d;
      out_q     <= out_d;
      winner_q  <= winner_d;
      iter_q    <= iter_d;
      tie_q     <= tie_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    shadow_d  = shadow_q;
    eps_d     = eps_q;
    s_d       = s_q;
    k_d       = k_q;
    busy_d    = busy_q;
    finish_d  = 1'b0;
    out_d     = out_q;
    winner_d  = winner_q;
    iter_d    = iter_q;
    tie_d     = tie_q;
    timeout_d = timeout_q;

    sum_c = '0;
    for (int i = 0; i < int'(N); i++) sum_c = sum_c + SW'(a_q[i]);

    // One channel per UPD cycle, always from the committed activations
    a_k_c     = a_q[k_q];
    diff_c    = s_q - SW'(a_k_c);
    prod_c    = PW'(eps_q) * PW'(diff_c);
    p_c       = QW'(prod_c >> F);
    upd_val_c = (p_c >= QW'(a_k_c)) ? '0 : (a_k_c - W'(p_c));

    // Survivor scan over the freshly computed shadow values
    any_nz_c    = 1'b0;
    multi_nz_c  = 1'b0;
    first_idx_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (shadow_q[i] != '0) begin
        if (any_nz_c) multi_nz_c = 1'b1;
        else          first_idx_c = IDXW'(i);
        any_nz_c = 1'b1;
      end
    end
    iter_inc_c = iter_q + ITW'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < int'(N); i++) a_d[i] = bus.a_in[i*W +: W];
          eps_d     = bus.epsilon;
          iter_d    = '0;
          tie_d     = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_SUM;
        end
      end
      ST_SUM: begin
        s_d     = sum_c;
        k_d     = '0;
        state_d = ST_UPD;
      end
      ST_UPD: begin
        shadow_d[k_q] = upd_val_c;
        if (k_q == IDXW'(N - 1)) state_d = ST_CHK;
        else                     k_d = k_q + IDXW'(1);
      end
      ST_CHK: begin
        a_d    = shadow_q;
        iter_d = iter_inc_c;
        if (!multi_nz_c) begin
          // Single survivor, or all collapsed (first_idx_c is 0 then)
          out_d     = any_nz_c ? shadow_q[first_idx_c] : '0;
          winner_d  = first_idx_c;
          tie_d     = !any_nz_c;
          timeout_d = 1'b0;
          finish_d  = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else if (iter_inc_c == ITW'(MAX_ITER)) begin
          out_d     = shadow_q[first_idx_c];
          winner_d  = first_idx_c;
          tie_d     = 1'b0;
          timeout_d = 1'b1;
          finish_d  = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_SUM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.finish     = finish_q;
  assign bus.out        = out_q;
  assign bus.winner     = winner_q;
  assign bus.iter_count = iter_q;
  assign bus.tie        = tie_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_maxnet_engine.sv
// Testbench for maxnet_engine (N=4, W=16, F=8, MAX_ITER=8).
module tb_maxnet_engine;
  localparam int unsigned N        = 4;
  localparam int unsigned W        = 16;
  localparam int unsigned F        = 8;
  localparam int unsigned MAX_ITER = 8;
  localparam int unsigned IDXW     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ITW      = $clog2(MAX_ITER + 1);
  localparam int          CPI      = int'(N) + 2;

  typedef struct packed {
    logic [W-1:0]    out;
    logic [IDXW-1:0] winner;
    logic [ITW-1:0]  iters;
    logic            tie;
    logic            timeout;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  maxnet_engine_if #(.N(N), .W(W), .MAX_ITER(MAX_ITER)) bus ();

  maxnet_engine #(.N(N), .W(W), .F(F), .MAX_ITER(MAX_ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Iterate the Maxnet rule on whole arrays until it resolves
  function automatic res_t ref_model(input logic [N*W-1:0] ain, input logic [W-1:0] e);
    longint unsigned a [N];
    longint unsigned nxt [N];
    longint unsigned s, p;
    int nz, first;
    res_t r;
    r = '0;
    for (int i = 0; i < int'(N); i++) a[i] = 64'(ain[i*W +: W]);
    for (int it = 1; it <= int'(MAX_ITER); it++) begin
      s = 0;
      for (int i = 0; i < int'(N); i++) s += a[i];
      for (int i = 0; i < int'(N); i++) begin
        p = (64'(e) * (s - a[i])) >> F;
        nxt[i] = (p >= a[i]) ? 64'd0 : a[i] - p;
      end
      nz = 0;
      first = -1;
      for (int i = 0; i < int'(N); i++) begin
        a[i] = nxt[i];
        if (a[i] != 0) begin
          nz++;
          if (first < 0) first = i;
        end
      end
      r.iters = ITW'(it);
      if (nz == 0) begin
        r.tie = 1'b1;
        return r;
      end
      if (nz == 1 || it == int'(MAX_ITER)) begin
        r.out     = W'(a[first]);
        r.winner  = IDXW'(first);
        r.timeout = (nz > 1);
        return r;
      end
    end
    return r;
  endfunction

  function automatic res_t observed();
    return {bus.out, bus.winner, bus.iter_count, bus.tie, bus.timeout};
  endfunction

  function automatic logic [N*W-1:0] rand_acts();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(N); i++)
      v[i*W +: W] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 16'hFFFF));
    return v;
  endfunction

  // Present a request and return right after the accepting edge
  task automatic launch(input logic [N*W-1:0] ain, input logic [W-1:0] e);
    bus.a_in    = ain;
    bus.epsilon = e;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
  endtask

  // Count cycles to finish; note whether busy ever dropped early
  task automatic wait_finish(output int cyc, output bit got, output bit busy_ok);
    cyc = 0;
    got = 1'b0;
    busy_ok = 1'b1;
    while (!got && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.finish) got = 1'b1;
      else if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a_in = '0;
    bus.epsilon = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.finish, observed()} !== '0) begin
      failures++;
      $display("FAIL reset: got busy=%b finish=%b res=%h, want all zero", bus.busy, bus.finish, observed());
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [N*W-1:0] ain [4];
    logic [W-1:0]   eps [4];
    res_t           exp [4];
    int             ecyc [4];
    int cyc; bit got, bok;
    ain[0] = {16'h0040, 16'h0080, 16'h0300, 16'h0100}; eps[0] = 16'h0080;
    exp[0] = {16'h0220, 2'd1, 4'd1, 1'b0, 1'b0};      ecyc[0] = 6;
    ain[1] = {16'h0000, 16'h0500, 16'h0000, 16'h0000}; eps[1] = 16'h0033;
    exp[1] = {16'h0500, 2'd2, 4'd1, 1'b0, 1'b0};      ecyc[1] = 6;
    ain[2] = {16'h0100, 16'h0100, 16'h0100, 16'h0100}; eps[2] = 16'h0080;
    exp[2] = {16'h0000, 2'd0, 4'd1, 1'b1, 1'b0};      ecyc[2] = 6;
    ain[3] = {16'h0000, 16'h0000, 16'h0100, 16'h0100}; eps[3] = 16'h0010;
    exp[3] = {16'h009B, 2'd0, 4'd8, 1'b0, 1'b1};      ecyc[3] = 48;
    for (int t = 0; t < 4; t++) begin
      launch(ain[t], eps[t]);
      wait_finish(cyc, got, bok);
      checks++;
      if (!got || cyc != ecyc[t] || !bok) begin
        failures++;
        $display("FAIL directed%0d_timing: got finish=%b after %0d cycles busy_ok=%b, want %0d cycles",
                 t, got, cyc, bok, ecyc[t]);
      end
      checks++;
      if (observed() !== exp[t]) begin
        failures++;
        $display("FAIL directed%0d_result: got %h, want %h", t, observed(), exp[t]);
      end
    end
  endtask

  task automatic test_random();
    logic [N*W-1:0] ain;
    logic [W-1:0]   e;
    res_t exp;
    int cyc; bit got, bok;
    for (int t = 0; t < 24; t++) begin
      ain = rand_acts();
      e   = W'($urandom_range(16'h0010, 16'h0055));
      exp = ref_model(ain, e);
      launch(ain, e);
      wait_finish(cyc, got, bok);
      checks++;
      if (!got || cyc != int'(exp.iters) * CPI || !bok) begin
        failures++;
        $display("FAIL random%0d_timing: got finish=%b after %0d cycles busy_ok=%b, want %0d cycles",
                 t, got, cyc, bok, int'(exp.iters) * CPI);
      end
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL random%0d_result: a=%h eps=%h got %h, want %h", t, ain, e, observed(), exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [N*W-1:0] ain;
    res_t exp;
    int cyc; bit got, bok;
    ain = {16'h0010, 16'h0200, 16'h0900, 16'h0040};
    exp = ref_model(ain, 16'h0040);
    launch(ain, 16'h0040);
    @(posedge clk);
    #1;
    bus.a_in = {16'h0F00, 16'h0000, 16'h0000, 16'h0000};
    bus.epsilon = 16'h0001;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_finish(cyc, got, bok);
    cyc += 2;
    checks++;
    if (!got || cyc != int'(exp.iters) * CPI) begin
      failures++;
      $display("FAIL ignore_start_timing: got finish=%b after %0d cycles, want %0d",
               got, cyc, int'(exp.iters) * CPI);
    end
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL ignore_start_result: got %h, want %h", observed(), exp);
    end
  endtask

  task automatic test_abort();
    logic [N*W-1:0] ain;
    logic [W-1:0]   e;
    res_t exp;
    bit saw;
    int cyc; bit got, bok;
    launch({16'h0040, 16'h0080, 16'h0300, 16'h0100}, 16'h0080);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.a_in = {16'h1000, 16'h0000, 16'h0000, 16'h0000};
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.finish, observed()} !== '0) begin
      failures++;
      $display("FAIL abort_reset_state: got busy=%b finish=%b res=%h, want all zero",
               bus.busy, bus.finish, observed());
    end
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.finish || bus.busy) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_finish: got activity=%b after abort, want 0", saw);
    end
    ain = rand_acts();
    e   = W'($urandom_range(16'h0020, 16'h0055));
    exp = ref_model(ain, e);
    launch(ain, e);
    wait_finish(cyc, got, bok);
    checks++;
    if (!got || cyc != int'(exp.iters) * CPI || observed() !== exp) begin
      failures++;
      $display("FAIL abort_rerun: got finish=%b cycles=%0d res=%h, want %0d cycles res=%h",
               got, cyc, observed(), int'(exp.iters) * CPI, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] ain_a, ain_b;
    res_t exp_a, exp_b;
    int cyc; bit got, bok;
    ain_a = {16'h0000, 16'h0700, 16'h0100, 16'h0000};
    ain_b = {16'h0300, 16'h0050, 16'h0000, 16'h0400};
    exp_a = ref_model(ain_a, 16'h0050);
    exp_b = ref_model(ain_b, 16'h0030);
    launch(ain_a, 16'h0050);
    wait_finish(cyc, got, bok);
    checks++;
    if (!got || bus.busy !== 1'b0 || observed() !== exp_a) begin
      failures++;
      $display("FAIL b2b_first: got finish=%b busy=%b res=%h, want finish=1 busy=0 res=%h",
               got, bus.busy, observed(), exp_a);
    end
    launch(ain_b, 16'h0030);
    checks++;
    if (bus.busy !== 1'b1 || bus.finish !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b finish=%b, want busy=1 finish=0", bus.busy, bus.finish);
    end
    wait_finish(cyc, got, bok);
    checks++;
    if (!got || !bok || cyc != int'(exp_b.iters) * CPI || observed() !== exp_b) begin
      failures++;
      $display("FAIL b2b_second: got finish=%b busy_ok=%b cycles=%0d res=%h, want %0d cycles res=%h",
               got, bok, cyc, observed(), int'(exp_b.iters) * CPI, exp_b);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, want completion before time limit");
    $fatal(1);
  end
endmodule

// File: doc/maxnet_engine.md
# maxnet_engine

Parametrised, fixed-point Maxnet winner-take-all engine, the next-generation successor to the 4-input Maxnet model. It loads N non-negative activations and a lateral-inhibition weight epsilon on `start`. It iterates a_i ← max(0, a_i − ε·Σ_{j≠i} a_j) until at most one activation remains non-zero. It then reports the winner's index and value, the iteration count, and tie/timeout status. It sits behind the feature-scoring stage and feeds the decision logic.

## Interface
- `N`, 4: number of channels (2..16).
- `W`, 16: activation/epsilon width, unsigned fixed point.
- `F`, 8: fraction bits of the Q(W−F).F format.
- `MAX_ITER`, 255: iteration limit before timeout (≥1).
- Derived: IDXW = max(1,$clog2(N)); ITW = $clog2(MAX_ITER+1).

Ports:
- `clk` in 1: clock; one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch request; sampled only when `busy`=0.
- `epsilon` in W: inhibition weight (same Q format); latched at start.
- `a_in` in N*W: initial activations; channel i = a_in[i*W +: W]; latched at start.
- `busy` out 1: high from the edge that accepts start until the edge that raises finish.
- `finish` out 1: one-cycle pulse; result outputs are valid from this cycle.
- `out` out W: winner activation value.
- `winner` out IDXW: winner channel index.
- `iter_count` out ITW: iterations executed.
- `tie` out 1: all channels collapsed to zero.
- `timeout` out 1: MAX_ITER reached without convergence.

## Operation
States: IDLE, SUM, UPD, CHK.

IDLE
- On `start`=1: latch a_in into a[0..N−1] and epsilon into eps.
- Clear iter_count, tie, timeout.
- Set busy=1 and go to SUM.

SUM (1 cycle)
- S = Σ a_i, held in W+IDXW bits with no truncation.

UPD (N cycles, channel k = 0..N−1 in order)
- p = (eps × (S − a_k)) >> F, full-width product, truncated toward zero.
- shadow_k = (p ≥ a_k) ? 0 : a_k − p.
- Always compute from the old a; a is never modified during UPD.

CHK (1 cycle)
- Commit shadow → a; iter_count += 1.
- Evaluate the committed values:
  - Exactly one non-zero: out = that value, winner = its index, tie=0, timeout=0; finish.
  - None non-zero: out=0, winner=0, tie=1; finish.
  - ≥2 non-zero and iter_count == MAX_ITER: timeout=1, out/winner = lowest-index non-zero channel; finish.
  - Otherwise go to SUM.
- On finish: next state is IDLE, busy=0, finish pulses for that one cycle.

Rules
- `start` while busy=1 is ignored with no side effects.
- `start` in the finish cycle is accepted, since busy=0.
- out, winner, iter_count, tie and timeout hold until the next accepted start.
- Epsilon range (ε < 1/(N−1) for guaranteed separation) is the caller's responsibility and is not checked.
- Inputs are unsigned; no saturation is needed because subtraction clamps at 0.

## Timing
- Reset: state=IDLE; busy, finish, out, winner, iter_count, tie, timeout all 0; internal a/eps/S cleared.
- One iteration takes N+2 cycles.
- finish rises exactly k·(N+2) cycles after the accepting edge for k iterations (N=4: 6 cycles per iteration).
- Even a single non-zero input runs one iteration (k ≥ 1).
- `rst` at any cycle, including mid-UPD, aborts the run with no finish pulse and restores reset values on the next edge; `rst` has priority over `start`.

## Test plan
- N=4, W=16, F=8, eps=0x0080, a=[0x0100,0x0300,0x0080,0x0040] → finish 6 cycles after start, winner=1, out=0x0220, iter_count=1, tie=0, timeout=0.
- a=[0,0,0x0500,0], eps=0x0033 → finish at 6 cycles, winner=2, out=0x0500, iter_count=1.
- a=[0x0100 ×4], eps=0x0080 → all collapse to 0: tie=1, out=0, winner=0, iter_count=1.
- MAX_ITER=8, a=[0x0100,0x0100,0,0], eps=0x0010 → timeout=1 after 48 cycles, iter_count=8, winner=0, out=0x009B.
- Start run 1, pulse start again at cycle 3 (ignored), assert rst at cycle 4 → no finish, all outputs 0. A new start then completes normally with bit-exact results against the reference model.
- Back-to-back: start asserted in the finish cycle is accepted; second result is correct; busy stays low for exactly that one cycle.
